multu_hilo: RTL and testbench



---
 rtl/multu_hilo_if.sv | 43 ++++
 rtl/multu_hilo.sv | 125 ++++++++++++
 tb/tb_multu_hilo.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multu_hilo_if.sv
// rtl/multu_hilo_if.sv - operand/function-code bus and HI/LO result bus for multu_hilo
//
// Signals:
//   data_a  [31:0]  multiplicand, sampled only on the start edge
//   data_b  [31:0]  multiplier, sampled only on the start edge
//   signal  [5:0]   function code; MULTU starts a multiply when the unit is idle
//   hi_out  [31:0]  HI register (upper half of the last completed product)
//   lo_out  [31:0]  LO register (lower half of the last completed product)
//   busy            high while a multiply is running or being committed
//   done            one-cycle pulse in the cycle after HI/LO are written
//
// master: the instruction/operand side that drives codes and operands.
// slave:  the multiplier unit itself.

interface multu_hilo_if;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [5:0]  signal;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;

    modport master (
        output data_a,
        output data_b,
        output signal,
        input  hi_out,
        input  lo_out,
        input  busy,
        input  done
    );

    modport slave (
        input  data_a,
        input  data_b,
        input  signal,
        output hi_out,
        output lo_out,
        output busy,
        output done
    );
endinterface

// File: rtl/multu_hilo.sv
// rtl/multu_hilo.sv - sequential unsigned 32x32 shift-add multiplier with HI/LO register pair
//
// Ports:
//   i_clk    single clock, all state updates on the rising edge
//   i_rst    asynchronous, active-high reset; clears all state including HI/LO
//   io_bus   multu_hilo_if.slave: data_a/data_b/signal in, hi_out/lo_out/busy/done out
//
// A MULTU code seen while idle captures the operands and runs 32 shift-add
// iterations (one per clock), then commits the 64-bit product to HI/LO on the
// following edge. HI/LO are driven continuously so a downstream result MUX can
// return them for MFHI/MFLO. Codes arriving while busy are ignored.

module multu_hilo #(
    parameter logic [5:0] MULTU_CODE = 6'b011001
) (
    input  logic         i_clk,
    input  logic         i_rst,
    multu_hilo_if.slave  io_bus
);

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     w_mcand_nxt;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   w_prod_nxt;
    logic [4:0]           r_cnt;
    logic [4:0]           w_cnt_nxt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     w_hi_nxt;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     w_lo_nxt;
    logic                 r_done;
    logic                 w_done_nxt;

    logic                 w_start;
    logic [WIDTH:0]       w_addend;
    logic [WIDTH:0]       w_sum;

    // A start is only recognised in IDLE; in RUN/WRITE the code is ignored,
    // so there is no restart and no queueing of a second request.
    assign w_start = (r_state == S_IDLE) && (io_bus.signal == MULTU_CODE);

    // One shift-add step. The add is 33 bits wide so the carry out of the
    // upper half survives the right shift and lands in bit 63 of prod.
    assign w_addend = r_prod[0] ? {1'b0, r_mcand} : '0;
    assign w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + w_addend;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mcand <= w_mcand_nxt;
            r_prod  <= w_prod_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mcand_nxt = r_mcand;
        w_prod_nxt  = r_prod;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_mcand_nxt = io_bus.data_a;
                    w_prod_nxt  = {{WIDTH{1'b0}}, io_bus.data_b};
                    w_cnt_nxt   = 5'd0;
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                // The multiplier bits are consumed from prod[0] as the
                // partial product shifts in from the top.
                w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
                w_cnt_nxt  = r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    w_state_nxt = S_WRITE;
                end
            end

            S_WRITE: begin
                w_hi_nxt    = r_prod[2*WIDTH-1:WIDTH];
                w_lo_nxt    = r_prod[WIDTH-1:0];
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign io_bus.hi_out = r_hi;
    assign io_bus.lo_out = r_lo;
    assign io_bus.busy   = (r_state == S_RUN) || (r_state == S_WRITE);
    assign io_bus.done   = r_done;

endmodule

// File: tb/tb_multu_hilo.sv
// tb/tb_multu_hilo.sv - randomized self-checking bench for multu_hilo against a product/latency model

module tb_multu_hilo;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] ADD   = 6'b100000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multu_hilo_if bus ();

    multu_hilo dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    logic check_en = 1'b0;

    // Model: a started multiply becomes visible on HI/LO exactly 33 edges
    // after the start edge, with value a*b; busy covers the gap in between.
    logic        m_active = 1'b0;
    int          m_left   = 0;
    logic [63:0] m_prod   = '0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;
    logic        m_done   = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_left   <= 0;
            m_prod   <= '0;
            m_hi     <= '0;
            m_lo     <= '0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (m_left == 1) begin
                    m_hi     <= m_prod[63:32];
                    m_lo     <= m_prod[31:0];
                    m_done   <= 1'b1;
                    m_active <= 1'b0;
                end
                m_left <= m_left - 1;
            end else if (bus.signal == MULTU) begin
                m_active <= 1'b1;
                m_left   <= 33;
                m_prod   <= {32'b0, bus.data_a} * {32'b0, bus.data_b};
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy_vs_model", {63'b0, bus.busy}, {63'b0, m_active});
            chk("done_vs_model", {63'b0, bus.done}, {63'b0, m_done});
            chk("hi_vs_model",   {32'b0, bus.hi_out}, {32'b0, m_hi});
            chk("lo_vs_model",   {32'b0, bus.lo_out}, {32'b0, m_lo});
        end
    end

    function automatic logic [5:0] other_code();
        logic [5:0] c;
        c = 6'($urandom_range(0, 63));
        if (c == MULTU) c = 6'd0;
        return c;
    endfunction

    // Presents MULTU for one edge; e0 is the edge number of the start edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int e0);
        bus.signal = MULTU;
        bus.data_a = a;
        bus.data_b = b;
        @(posedge clk);
        #1;
        e0 = edge_n;
        bus.signal = other_code();
        bus.data_a = $urandom;
        bus.data_b = $urandom;
    endtask

    // Returns the number of edges from e0 to the edge that raised done
    // (-1 on timeout) and the number of sampled cycles busy was high.
    task automatic wait_done(input int e0, output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = edge_n - e0;
                break;
            end
            if (bus.busy) busy_cycles++;
            bus.signal = other_code();
        end
    endtask

    task automatic wait_edge(input int n);
        for (int i = 0; i < 200 && edge_n < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int e0, lat, bc;
        start_op(a, b, e0);
        wait_done(e0, lat, bc);
        chk({name, "_latency"}, 64'(lat), 64'd33);
        chk({name, "_hi"}, {32'b0, bus.hi_out}, {32'b0, exp_hi});
        chk({name, "_lo"}, {32'b0, bus.lo_out}, {32'b0, exp_lo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, lat, bc, n;
        logic [31:0] a, b, h0, l0;
        logic [63:0] p;

        bus.signal = 6'd0;
        bus.data_a = '0;
        bus.data_b = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi",   {32'b0, bus.hi_out}, 64'd0);
        chk("reset_lo",   {32'b0, bus.lo_out}, 64'd0);
        chk("reset_busy", {63'b0, bus.busy}, 64'd0);
        chk("reset_done", {63'b0, bus.done}, 64'd0);
        rst = 1'b0;
        check_en = 1'b1;
        @(posedge clk);
        #1;

        // Basic multiply with busy-duration check.
        start_op(32'd3, 32'd5, e0);
        wait_done(e0, lat, bc);
        chk("basic_latency", 64'(lat), 64'd33);
        chk("basic_busy_cycles", 64'(bc), 64'd33);
        chk("basic_hi", {32'b0, bus.hi_out}, 64'h0);
        chk("basic_lo", {32'b0, bus.lo_out}, 64'hF);

        run_op("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("carry", 32'h80000000, 32'd2, 32'h00000001, 32'h00000000);
        run_op("mixed", 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 32'h242D2080);

        // MULTU with new operands while busy must be ignored.
        start_op(32'd7, 32'd6, e0);
        wait_edge(e0 + 9);
        bus.signal = MULTU;
        bus.data_a = 32'hFFFFFFFF;
        bus.data_b = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.signal = ADD;
        wait_done(e0, lat, bc);
        chk("busy_ign_latency", 64'(lat), 64'd33);
        chk("busy_ign_hi", {32'b0, bus.hi_out}, 64'd0);
        chk("busy_ign_lo", {32'b0, bus.lo_out}, 64'd42);

        // Non-MULTU codes hold HI/LO and keep done low.
        n = 0;
        for (int i = 0; i < 50; i++) begin
            case (i % 4)
                0: bus.signal = MFHI;
                1: bus.signal = MFLO;
                2: bus.signal = ADD;
                default: bus.signal = 6'd0;
            endcase
            bus.data_a = $urandom;
            bus.data_b = $urandom;
            @(negedge clk);
            if (bus.done || bus.busy) n++;
        end
        chk("hold_no_activity", 64'(n), 64'd0);
        chk("hold_hi", {32'b0, bus.hi_out}, 64'd0);
        chk("hold_lo", {32'b0, bus.lo_out}, 64'd42);

        // Reset mid-operation discards the partial product and zeroes HI/LO.
        run_op("preset", 32'h80000001, 32'd2, 32'h00000001, 32'h00000002);
        start_op($urandom, $urandom, e0);
        wait_edge(e0 + 15);
        rst = 1'b1;
        #1;
        chk("midrst_hi",   {32'b0, bus.hi_out}, 64'd0);
        chk("midrst_lo",   {32'b0, bus.lo_out}, 64'd0);
        chk("midrst_busy", {63'b0, bus.busy}, 64'd0);
        chk("midrst_done", {63'b0, bus.done}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.signal = ADD;
        count_done(40, n);
        chk("midrst_no_done", 64'(n), 64'd0);

        // MULTU held continuously restarts every 34 edges.
        bus.signal = MULTU;
        n = 0;
        for (int i = 0; i < 70; i++) begin
            bus.data_a = $urandom;
            bus.data_b = $urandom;
            @(negedge clk);
            if (bus.done) n++;
        end
        bus.signal = MFLO;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        chk("continuous_done_count", 64'(n), 64'd3);

        // Randomized operands with random idle gaps.
        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 4))
                0: a = 32'hFFFFFFFF;
                1: a = 32'd0;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
            p = {32'b0, a} * {32'b0, b};
            h0 = bus.hi_out;
            l0 = bus.lo_out;
            start_op(a, b, e0);
            wait_edge(e0 + 20);
            chk("rand_hold_hi", {32'b0, bus.hi_out}, {32'b0, h0});
            chk("rand_hold_lo", {32'b0, bus.lo_out}, {32'b0, l0});
            wait_done(e0, lat, bc);
            chk("rand_latency", 64'(lat), 64'd33);
            chk("rand_product", {bus.hi_out, bus.lo_out}, p);
            repeat ($urandom_range(0, 5)) begin
                bus.signal = other_code();
                @(posedge clk);
                #1;
            end
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
